// File: rtl/mul_control_unit_if.sv
// Control bundle between the multi-cycle control unit and the datapath:
// opcode/zero flow in, state and datapath enables flow out.
interface mul_control_unit_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic [3:0]      state;
    logic            IRWre;
    logic            PCWre;
    logic [1:0]      PCSrc;
    logic            InsMemRW;
    logic            RegWre;
    logic            DataMemRW;
    logic            ALUSrcB;
    logic            ExtSel;
    logic            RegOut;
    logic            ALUM2Reg;
    logic [2:0]      ALUOp;

    modport master (
        output opcode, zero,
        input  state, IRWre, PCWre, PCSrc,
        input  InsMemRW, RegWre, DataMemRW,
        input  ALUSrcB, ExtSel, RegOut,
        input  ALUM2Reg, ALUOp
    );

    modport slave (
        input  opcode, zero,
        output state, IRWre, PCWre, PCSrc,
        output InsMemRW, RegWre, DataMemRW,
        output ALUSrcB, ExtSel, RegOut,
        output ALUM2Reg, ALUOp
    );
endinterface

// File: rtl/mul_control_unit.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer for a small
// MIPS-like datapath; all outputs decode from state and opcode.
module mul_control_unit #(
    parameter int OP_W = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    mul_control_unit_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0110,
        S_EXE_BR = 4'b0101,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_AL  = 4'b0111,
        S_WB_LD  = 4'b0100,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
    localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
    localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OP_W-1:0] OP_J    = 6'b111000;
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    state_t st, st_nxt;

    logic is_add, is_sub, is_addi, is_or, is_and, is_ori;
    logic is_sw, is_lw, is_beq, is_j, is_halt;
    logic is_rtype, is_alu, is_ls;

    assign is_add   = bus.opcode == OP_ADD;
    assign is_sub   = bus.opcode == OP_SUB;
    assign is_addi  = bus.opcode == OP_ADDI;
    assign is_or    = bus.opcode == OP_OR;
    assign is_and   = bus.opcode == OP_AND;
    assign is_ori   = bus.opcode == OP_ORI;
    assign is_sw    = bus.opcode == OP_SW;
    assign is_lw    = bus.opcode == OP_LW;
    assign is_beq   = bus.opcode == OP_BEQ;
    assign is_j     = bus.opcode == OP_J;
    assign is_halt  = bus.opcode == OP_HALT;
    assign is_rtype = is_add | is_sub | is_or | is_and;
    assign is_alu   = is_rtype | is_addi | is_ori;
    assign is_ls    = is_sw | is_lw;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) st <= S_IF;
        else        st <= st_nxt;
    end

    logic       irw, pcw, regw, dmw, m2r;
    logic [1:0] pcsrc;

    always_comb begin
        st_nxt = st;
        irw    = 1'b0;
        pcw    = 1'b0;
        pcsrc  = 2'b00;
        regw   = 1'b0;
        dmw    = 1'b0;
        m2r    = 1'b0;
        unique case (st)
            S_IF: begin
                st_nxt = S_ID;
                irw    = 1'b1;
            end
            S_ID: begin
                unique case (1'b1)
                    is_alu:  st_nxt = S_EXE_AL;
                    is_beq:  st_nxt = S_EXE_BR;
                    is_ls:   st_nxt = S_EXE_LS;
                    // PC is left on the halt word itself
                    is_halt: st_nxt = S_HALT;
                    default: begin
                        st_nxt = S_IF;
                        pcw    = 1'b1;
                        if (is_j) pcsrc = 2'b11;
                    end
                endcase
            end
            S_EXE_AL: st_nxt = S_WB_AL;
            S_WB_AL: begin
                st_nxt = S_IF;
                pcw    = 1'b1;
                regw   = is_alu;
            end
            S_EXE_BR: begin
                st_nxt = S_IF;
                pcw    = 1'b1;
                pcsrc  = bus.zero ? 2'b01 : 2'b00;
            end
            S_EXE_LS: st_nxt = S_MEM;
            S_MEM: begin
                if (is_lw) begin
                    st_nxt = S_WB_LD;
                end else begin
                    st_nxt = S_IF;
                    pcw    = 1'b1;
                    dmw    = is_sw;
                end
            end
            S_WB_LD: begin
                st_nxt = S_IF;
                pcw    = 1'b1;
                regw   = is_lw;
                m2r    = 1'b1;
            end
            S_HALT: st_nxt = S_HALT;
            default: st_nxt = S_IF;
        endcase
    end

    always_comb begin
        bus.ALUOp = 3'b000;
        unique case (1'b1)
            is_sub | is_beq: bus.ALUOp = 3'b001;
            is_or | is_ori:  bus.ALUOp = 3'b011;
            is_and:          bus.ALUOp = 3'b100;
            default:         bus.ALUOp = 3'b000;
        endcase
    end

    // write strobes are masked by Reset so an abort is immediate
    assign bus.state     = st;
    assign bus.IRWre     = Reset & irw;
    assign bus.PCWre     = Reset & pcw;
    assign bus.PCSrc     = pcsrc;
    assign bus.InsMemRW  = st != S_HALT;
    assign bus.RegWre    = Reset & regw;
    assign bus.DataMemRW = Reset & dmw;
    assign bus.ALUSrcB   = is_addi | is_ori | is_lw | is_sw;
    assign bus.ExtSel    = ~is_ori;
    assign bus.RegOut    = is_rtype;
    assign bus.ALUM2Reg  = m2r;
endmodule
